// File: rtl/acsu_param_if.sv
// Symbol/decision bundle between a Viterbi front end and the add-compare-select unit.
// The master drives start and symbols; the slave (ACS unit) returns decisions and metrics.
interface acsu_param_if #(
    parameter int M = 3,
    parameter int W = 8
);
    localparam int NS = 1 << M;

    logic              start;
    logic              start_known;
    logic              sym_valid;
    logic [1:0]        sym;
    logic              dec_valid;
    logic [NS-1:0]     dec;
    logic [M-1:0]      best_state;
    logic [W-1:0]      best_metric;
    logic              norm_event;
    logic [NS*W-1:0]   pm_flat;

    modport master (
        output start, start_known, sym_valid, sym,
        input  dec_valid, dec, best_state, best_metric, norm_event, pm_flat
    );

    modport slave (
        input  start, start_known, sym_valid, sym,
        output dec_valid, dec, best_state, best_metric, norm_event, pm_flat
    );
endinterface

// File: rtl/acsu_param.sv
// Parametrised add-compare-select array for a rate-1/2 hard-decision Viterbi decoder.
// One trellis stage per accepted symbol; path metrics are kept bounded by modulo normalisation.
module acsu_param #(
    parameter int           M         = 3,
    parameter int           W         = 8,
    parameter logic [M:0]   G0        = 4'b1101,
    parameter logic [M:0]   G1        = 4'b1111,
    parameter int           INIT_BIAS = 16
) (
    input  logic         clock,
    input  logic         reset,
    acsu_param_if.slave  bus
);
    localparam int NS = 1 << M;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic parity(input logic [M:0] v);
        return ^v;
    endfunction

    // Hamming distance between the received pair and the branch label for tap vector {u, s}.
    function automatic logic [1:0] branch_metric(input logic [M:0] tap, input logic [1:0] rx);
        logic c0;
        logic c1;
        c0 = parity(G0 & tap);
        c1 = parity(G1 & tap);
        return {1'b0, c0 ^ rx[0]} + {1'b0, c1 ^ rx[1]};
    endfunction

    state_t           state_r;
    logic [W-1:0]     pm_r [NS];
    logic [NS-1:0]    dec_r;
    logic [M-1:0]     best_state_r;
    logic [W-1:0]     best_metric_r;
    logic             norm_r;

    logic [W:0]       cand0_s [NS];
    logic [W:0]       cand1_s [NS];
    logic [W-1:0]     sel_s [NS];
    logic [W-1:0]     new_pm_s [NS];
    logic [NS-1:0]    dec_s;
    logic [NS-1:0]    msb_s;
    logic             norm_s;
    logic [M-1:0]     best_state_s;
    logic [W-1:0]     best_metric_s;
    logic [NS*W-1:0]  pm_flat_s;

    // Butterfly wiring: state j is reached from p0 = 2j mod NS and p1 = p0 + 1 with input u = j[M-1].
    for (genvar j = 0; j < NS; j++) begin : g_acs
        localparam int           P0 = (2 * j) % NS;
        localparam int           P1 = P0 + 1;
        localparam logic [M-1:0] S0 = M'(P0);
        localparam logic [M-1:0] S1 = M'(P1);
        localparam logic         UJ = 1'((j >> (M - 1)) & 1);

        logic [W:0] sel_wide_s;

        assign cand0_s[j]  = {1'b0, pm_r[P0]} + {{(W-1){1'b0}}, branch_metric({UJ, S0}, bus.sym)};
        assign cand1_s[j]  = {1'b0, pm_r[P1]} + {{(W-1){1'b0}}, branch_metric({UJ, S1}, bus.sym)};
        assign dec_s[j]    = (cand1_s[j] < cand0_s[j]);
        assign sel_wide_s  = dec_s[j] ? cand1_s[j] : cand0_s[j];
        assign sel_s[j]    = sel_wide_s[W] ? {W{1'b1}} : sel_wide_s[W-1:0];
        assign msb_s[j]    = sel_s[j][W-1];
        // Subtracting 2^(W-1) from a value whose top bit is set is just clearing that bit.
        assign new_pm_s[j] = norm_s ? {1'b0, sel_s[j][W-2:0]} : sel_s[j];
    end

    assign norm_s = &msb_s;

    // Minimum search over the new metrics; strict compare keeps the lowest index on ties.
    always_comb begin
        best_state_s  = {M{1'b0}};
        best_metric_s = new_pm_s[0];
        for (int j = 1; j < NS; j++) begin
            if (new_pm_s[j] < best_metric_s) begin
                best_state_s  = M'(j);
                best_metric_s = new_pm_s[j];
            end else begin
                best_state_s  = best_state_s;
                best_metric_s = best_metric_s;
            end
        end
    end

    // Flatten the metric registers for the output bus.
    always_comb begin
        pm_flat_s = {(NS*W){1'b0}};
        for (int j = 0; j < NS; j++) begin
            pm_flat_s[j*W +: W] = pm_r[j];
        end
    end

    // Metric registers, decision outputs and the IDLE/RUN state machine.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= IDLE;
            dec_r         <= {NS{1'b0}};
            best_state_r  <= {M{1'b0}};
            best_metric_r <= {W{1'b0}};
            norm_r        <= 1'b0;
            for (int j = 0; j < NS; j++) begin
                pm_r[j] <= {W{1'b0}};
            end
        end else if (bus.start) begin
            state_r       <= IDLE;
            dec_r         <= {NS{1'b0}};
            best_state_r  <= {M{1'b0}};
            best_metric_r <= {W{1'b0}};
            norm_r        <= 1'b0;
            pm_r[0]       <= {W{1'b0}};
            for (int j = 1; j < NS; j++) begin
                pm_r[j] <= bus.start_known ? W'(INIT_BIAS) : {W{1'b0}};
            end
        end else if (bus.sym_valid) begin
            state_r       <= RUN;
            dec_r         <= dec_s;
            best_state_r  <= best_state_s;
            best_metric_r <= best_metric_s;
            norm_r        <= norm_s;
            for (int j = 0; j < NS; j++) begin
                pm_r[j] <= new_pm_s[j];
            end
        end else begin
            state_r <= IDLE;
            norm_r  <= 1'b0;
        end
    end

    assign bus.dec_valid   = (state_r == RUN);
    assign bus.dec         = dec_r;
    assign bus.best_state  = best_state_r;
    assign bus.best_metric = best_metric_r;
    assign bus.norm_event  = norm_r;
    assign bus.pm_flat     = pm_flat_s;
endmodule

// File: tb/tb_acsu_param.sv
// Bench for acsu_param (M=3, W=8, G0=1101, G1=1111, INIT_BIAS=16): hand-computed vector table,
// then a long encoded stream with bit errors, idle gaps and a noise tail against a forward-form model.
module tb_acsu_param;
    localparam logic [3:0] G0 = 4'b1101;
    localparam logic [3:0] G1 = 4'b1111;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   passed = 0;

    acsu_param_if #(.M(3), .W(8)) bus ();

    acsu_param dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n;
        logic        st;
        logic        known;
        logic        vld;
        logic [1:0]  sy;
        logic        e_dv;
        logic [7:0]  e_dec;
        logic [2:0]  e_bs;
        logic [7:0]  e_bm;
        logic        e_norm;
        logic [63:0] e_pm;
    } vec_t;

    vec_t vt [10];

    int          mpm [8];
    logic [7:0]  mdec;
    int          mbs;
    int          mbm;
    logic        mnorm;
    logic        mdv;
    int          dut_norms;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic known, input logic vld, input logic [1:0] sy);
        bus.start       = st;
        bus.start_known = known;
        bus.sym_valid   = vld;
        bus.sym         = sy;
    endtask

    task automatic model_init(input logic known);
        for (int k = 0; k < 8; k++) mpm[k] = (k == 0 || !known) ? 0 : 16;
        mdec = 8'h00; mbs = 0; mbm = 0; mnorm = 1'b0; mdv = 1'b0;
    endtask

    // Forward trellis walk: every (state, input) pair offers a candidate to its successor.
    task automatic model_step(input logic [1:0] sy);
        int best [8];
        logic [7:0] d;
        logic [3:0] tap;
        int nxt, bm, cand;
        logic allhi;
        d = 8'h00;
        for (int k = 0; k < 8; k++) best[k] = -1;
        for (int s = 0; s < 8; s++) begin
            for (int u = 0; u < 2; u++) begin
                nxt  = (u << 2) | (s >> 1);
                tap  = {u[0], s[2:0]};
                bm   = int'((^(G0 & tap)) != sy[0]) + int'((^(G1 & tap)) != sy[1]);
                cand = mpm[s] + bm;
                if (best[nxt] < 0 || cand < best[nxt]) begin
                    best[nxt] = cand;
                    d[nxt]    = s[0];
                end
            end
        end
        allhi = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (best[k] > 255) best[k] = 255;
            if (best[k] < 128) allhi = 1'b0;
        end
        for (int k = 0; k < 8; k++) mpm[k] = allhi ? best[k] - 128 : best[k];
        mbs = 0;
        for (int k = 1; k < 8; k++) if (mpm[k] < mpm[mbs]) mbs = k;
        mbm = mpm[mbs]; mdec = d; mnorm = allhi; mdv = 1'b1;
    endtask

    function automatic logic [63:0] model_pm();
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(mpm[k]);
        return v;
    endfunction

    task automatic compare_model(input string tag);
        check({tag, "_dv"},   64'(bus.dec_valid),   64'(mdv));
        check({tag, "_dec"},  64'(bus.dec),         64'(mdec));
        check({tag, "_bs"},   64'(bus.best_state),  64'(mbs));
        check({tag, "_bm"},   64'(bus.best_metric), 64'(mbm));
        check({tag, "_norm"}, 64'(bus.norm_event),  64'(mnorm));
        check({tag, "_pm"},   bus.pm_flat,          model_pm());
    endtask

    initial begin
        logic [2:0] enc;
        logic       u;
        logic [3:0] tap;
        logic [1:0] sy;
        logic       vld;
        logic [7:0] msbs;

        drive(1'b0, 1'b0, 1'b0, 2'b00);
        reset = 1'b0;
        tick(); tick();
        check("reset_dv",   64'(bus.dec_valid),   64'd0);
        check("reset_dec",  64'(bus.dec),         64'd0);
        check("reset_bs",   64'(bus.best_state),  64'd0);
        check("reset_norm", 64'(bus.norm_event),  64'd0);
        check("reset_pm",   bus.pm_flat,          64'd0);

        //          rst   st    kn    vld   sym    dv    dec    bs    bm     norm  pm_flat {pm7..pm0}
        vt[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 3'd0, 8'd0, 1'b0, 64'h10101010_10101000};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h04, 3'd0, 8'd0, 1'b0, 64'h11101102_11101100};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 3'd0, 8'd0, 1'b0, 64'h11021102_11041100};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 8'h00, 3'd0, 8'd0, 1'b0, 64'h11021102_11041100};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 3'd0, 8'd0, 1'b0, 64'h00000000_00000000};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'h82, 3'd1, 8'd0, 1'b0, 64'h00010001_00010001};
        vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 8'h82, 3'd1, 8'd0, 1'b0, 64'h00010001_00010001};
        vt[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'hD7, 3'd1, 8'd0, 1'b0, 64'h00010101_01010001};
        vt[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 8'h00, 3'd0, 8'd0, 1'b0, 64'h00000000_00000000};
        vt[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 8'h82, 3'd1, 8'd0, 1'b0, 64'h00010001_00010001};

        for (int i = 0; i < 10; i++) begin
            reset = vt[i].rst_n;
            drive(vt[i].st, vt[i].known, vt[i].vld, vt[i].sy);
            tick();
            check($sformatf("vec%0d_dv", i),   64'(bus.dec_valid),   64'(vt[i].e_dv));
            check($sformatf("vec%0d_dec", i),  64'(bus.dec),         64'(vt[i].e_dec));
            check($sformatf("vec%0d_bs", i),   64'(bus.best_state),  64'(vt[i].e_bs));
            check($sformatf("vec%0d_bm", i),   64'(bus.best_metric), 64'(vt[i].e_bm));
            check($sformatf("vec%0d_norm", i), 64'(bus.norm_event),  64'(vt[i].e_norm));
            check($sformatf("vec%0d_pm", i),   bus.pm_flat,          vt[i].e_pm);
        end

        // Long stream from a known-zero encoder with bit errors, idle gaps, then a noise tail.
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'b00);
        tick();
        model_init(1'b1);
        compare_model("rstart");
        enc = 3'b000;
        dut_norms = 0;
        for (int i = 0; i < 2600; i++) begin
            vld = ($urandom_range(3) != 0);
            sy  = 2'($urandom_range(3));
            if (vld && i < 2000) begin
                u   = 1'($urandom_range(1));
                tap = {u, enc};
                sy  = {^(G1 & tap), ^(G0 & tap)};
                if ($urandom_range(19) == 0) sy[0] = ~sy[0];
                if ($urandom_range(19) == 0) sy[1] = ~sy[1];
                enc = {u, enc[2:1]};
            end
            drive(1'b0, 1'b0, vld, sy);
            tick();
            if (vld) model_step(sy);
            else begin
                mdv = 1'b0; mnorm = 1'b0;
            end
            compare_model("rand");
            if (bus.norm_event) begin
                dut_norms++;
                for (int k = 0; k < 8; k++) msbs[k] = bus.pm_flat[k*8 + 7];
                check("norm_msb_clear", 64'(msbs), 64'd0);
            end
        end
        check("norm_seen", 64'(dut_norms > 0), 64'd1);

        drive(1'b0, 1'b0, 1'b0, 2'b00);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/acsu_param.md
Name: acsu_param

Overview:
- Parametrised Add-Compare-Select unit for rate-1/2 hard-decision Viterbi decoders. Generalises the fixed 8-state ACS array to 2^M states.
- Computes branch metrics and applies trellis butterfly connectivity internally.
- Holds path metrics in registers and applies modulo normalisation. Reports the best state each update.
- Feeds the survivor/traceback memory with one decision vector per received symbol.

Parameters:
- M, 3, encoder memory; NS = 2^M states.
- W, 8, path-metric width in bits; W >= 4.
- G0, 4'b1101, generator polynomial for output bit 0 (M+1 bits; bit M taps the new input u, bit 0 taps the oldest state bit).
- G1, 4'b1111, generator polynomial for output bit 1.
- INIT_BIAS, 16, metric given to non-zero states on a known-start init; must be < 2^(W-1).

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-low.
- start, in, 1, one-cycle pulse that (re)initialises the path metrics.
- start_known, in, 1, sampled with start: 1 = encoder starts in state 0; 0 = all states equiprobable.
- sym_valid, in, 1, qualifies sym; one trellis stage per asserted cycle.
- sym, in, 2, received hard-decision symbol {c1,c0}.
- dec_valid, out, 1, decisions, best_state and best_metric are valid this cycle.
- dec, out, NS, decision bit per state (1 = odd predecessor chosen).
- best_state, out, M, index of the minimum new metric.
- best_metric, out, W, value of that minimum metric, after normalisation.
- norm_event, out, 1, high when this update applied normalisation.
- pm_flat, out, NS*W, current path metrics; state j is at bits [j*W +: W].

Behaviour:
- Trellis convention:
  - Next state = {u, s[M-1:1]}.
  - Predecessors of state j: p0 = (j<<1) mod NS and p1 = p0 | 1; input u = j[M-1].
  - Expected output c_i = XOR-reduce(G_i & {u, s}).
- Branch metric: Hamming distance between sym and {c1,c0}, range 0..2.
- ACS per state j:
  - cand0 = pm[p0] + bm0 and cand1 = pm[p1] + bm1, computed at W+1 bits.
  - dec[j] = 1 only if cand1 < cand0. On a tie, p0 wins and dec[j] = 0.
  - The selected candidate saturates to 2^W - 1 if it overflows (error condition, not expected in normal use).
- Normalisation:
  - If every selected candidate has bit W-1 set, 2^(W-1) is subtracted from all of them in the same update and norm_event = 1.
  - Otherwise norm_event = 0.
- Best state: lowest index among the minimum post-normalisation metrics. It is computed from the new metrics and registered alongside them.
- Latency: a symbol sampled at edge n produces updated pm_flat, dec, best_state, best_metric, norm_event and dec_valid = 1 after edge n (one cycle). dec_valid is a single-cycle pulse per accepted symbol. Back-to-back symbols are accepted every cycle; there is no backpressure.
- When sym_valid = 0: metrics hold, dec_valid = 0, norm_event = 0, and dec/best_state/best_metric hold their last values.
- Start:
  - On the next edge: pm[0] = 0, pm[j != 0] = INIT_BIAS if start_known = 1, else 0.
  - Also dec_valid = 0, norm_event = 0, dec = 0, best_state = 0, best_metric = 0.
  - If start and sym_valid are both high in the same cycle, start has priority and that symbol is dropped.
- Reset (reset = 0 at an edge):
  - All metrics 0, dec = 0, dec_valid = 0, best_state = 0, best_metric = 0, norm_event = 0.
  - Reset has priority over start and sym_valid.
  - Reset asserted mid-stream discards all in-flight state; the first symbol after reset is processed against all-zero metrics.
- State machine: IDLE (after reset, or when sym_valid is low) and RUN (sym_valid accepted). The metric registers are the only history; no symbol buffering.

Test Plan:
- Reset, then start with start_known = 1, then 6 cycles of sym = 2'b00 -> each update dec_valid = 1, pm[0] = 0, best_state = 0, best_metric = 0, dec[0] = 0, norm_event = 0. All other metrics match the golden model, which starts from 16.
- Reset, then start with start_known = 0, then one sym = 2'b01 -> dec[j] = 1 exactly for states whose p0 expected output is 2'b10; tied states give dec[j] = 0. best_state = lowest index with metric 0.
- Random 2000-symbol stream, errors injected at 1/20, start_known = 1 -> pm_flat, dec, best_state, norm_event match a bit-exact C model every cycle. At least one norm_event observed; after it, no metric has bit 7 set.
- Same cycle start = 1 and sym_valid = 1 -> next cycle dec_valid = 0 and metrics equal the init values (symbol dropped).
- Pulse sym_valid on alternate cycles -> dec_valid pulses exactly once per accepted symbol; outputs hold while sym_valid = 0.
- reset = 0 for one cycle mid-stream with sym_valid = 1 -> next cycle all outputs 0. The following symbol is computed from all-zero metrics.
